// File: rtl/plic_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plic_lite_pkg
//  Description : Shared register offsets, id width, context and access-FSM
//                state encodings for the plic_lite interrupt arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package plic_lite_pkg;

    // Source ids are 1..31 with 0 meaning "none", so five bits cover them all
    localparam int c_id_w = 5;

    // Register byte offsets (word aligned, bits [1:0] are ignored)
    localparam logic [7:0] c_reg_pend    = 8'h80;
    localparam logic [7:0] c_reg_en_m    = 8'h84;
    localparam logic [7:0] c_reg_en_s    = 8'h88;
    localparam logic [7:0] c_reg_thr_m   = 8'h8C;
    localparam logic [7:0] c_reg_thr_s   = 8'h90;
    localparam logic [7:0] c_reg_claim_m = 8'h94;
    localparam logic [7:0] c_reg_claim_s = 8'h98;

    typedef enum logic [0:0] {
        CTX_M = 1'b0,
        CTX_S = 1'b1
    } ctx_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway
//  Description : Level-triggered gateway for one interrupt source. Holds the
//                pending and in-flight bits; a claimed source cannot re-pend
//                until software completes it.
//  Revision    : 1.0  initial release
// ============================================================================
module plic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending
);

    logic r_pending;
    logic r_inflight;

    // Claim takes priority; otherwise latch the level and retire on complete
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_inflight <= 1'b0;
        end else if (i_claim) begin
            r_pending  <= 1'b0;
            r_inflight <= 1'b1;
        end else begin
            if (i_irq && !r_inflight) begin
                r_pending <= 1'b1;
            end
            if (i_complete) begin
                r_inflight <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/plic_lite.sv
`default_nettype none
// ============================================================================
//  Module      : plic_lite
//  Description : Platform-level interrupt arbiter with two targets (M and S
//                context). Per-source gateways, priority/threshold arbitration
//                and a single-outstanding register port for configuration and
//                claim/complete.
//  Revision    : 1.0  initial release
// ============================================================================
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_valid,
    input  logic               reg_we,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_ready,
    output logic               eip_m,
    output logic               eip_s
);

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [7:0]                    w_addr;
    logic                          w_accept;
    logic                          w_wr;
    logic                          w_rd;
    logic                          w_claim_m;
    logic                          w_claim_s;
    logic                          w_cmpl_sel;
    logic [c_id_w-1:0]             w_claim_id;
    logic [NUM_SRC-1:0]            w_pend;
    logic [NUM_SRC-1:0]            w_claim;
    logic [NUM_SRC-1:0]            w_complete;
    logic [PRIO_W-1:0]             r_prio [NUM_SRC];
    logic [1:0][NUM_SRC-1:0]       r_en;
    logic [1:0][PRIO_W-1:0]        r_thr;
    logic [1:0][c_id_w-1:0]        w_best;
    logic [1:0][c_id_w-1:0]        r_best;
    logic [1:0]                    r_eip;
    logic [31:0]                   w_rdata;
    logic [31:0]                   r_rdata;
    logic                          w_unused;

    assign w_addr     = {reg_addr[7:2], 2'b00};
    assign w_unused   = ^reg_addr[1:0];
    assign w_accept   = (r_state == IDLE) && reg_valid;
    assign w_wr       = w_accept && reg_we;
    assign w_rd       = w_accept && !reg_we;
    assign w_claim_m  = w_rd && (w_addr == c_reg_claim_m);
    assign w_claim_s  = w_rd && (w_addr == c_reg_claim_s);
    assign w_cmpl_sel = w_wr && ((w_addr == c_reg_claim_m) || (w_addr == c_reg_claim_s));
    // A claim consumes the registered winner of the addressed context; 0 claims nothing
    assign w_claim_id = w_claim_m ? r_best[CTX_M] :
                        w_claim_s ? r_best[CTX_S] : '0;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
            assign w_claim[i]    = (w_claim_id == c_id_w'(i + 1));
            assign w_complete[i] = w_cmpl_sel && (reg_wdata == 32'(i + 1));

            plic_gateway u_gw (
                .clk        (clk),
                .rst        (reset),
                .i_irq      (irq_src[i]),
                .i_claim    (w_claim[i]),
                .i_complete (w_complete[i]),
                .o_pending  (w_pend[i])
            );
        end
    endgenerate

    generate
        for (genvar c = 0; c < 2; c++) begin : g_arb
            logic [PRIO_W-1:0] w_max;

            // Priority-max scan: strict compare keeps the lowest id on ties
            always_comb begin
                w_max     = '0;
                w_best[c] = '0;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_pend[i] && r_en[c][i] && (r_prio[i] > r_thr[c]) &&
                        (r_prio[i] > w_max)) begin
                        w_max     = r_prio[i];
                        w_best[c] = c_id_w'(i + 1);
                    end
                end
            end
        end
    endgenerate

    // Per-source priority registers; id 0 and ids beyond NUM_SRC have no storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reset) begin
                r_prio[i] <= '0;
            end else if (w_wr && !w_addr[7] && (w_addr[6:2] == c_id_w'(i + 1))) begin
                r_prio[i] <= reg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Context configuration plus registered arbitration result and interrupt lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en   <= '0;
            r_thr  <= '0;
            r_best <= '0;
            r_eip  <= '0;
        end else begin
            r_best <= w_best;
            r_eip  <= {(w_best[CTX_S] != '0), (w_best[CTX_M] != '0)};
            if (w_wr) begin
                case (w_addr)
                    c_reg_en_m:  r_en[CTX_M]  <= reg_wdata[NUM_SRC:1];
                    c_reg_en_s:  r_en[CTX_S]  <= reg_wdata[NUM_SRC:1];
                    c_reg_thr_m: r_thr[CTX_M] <= reg_wdata[PRIO_W-1:0];
                    c_reg_thr_s: r_thr[CTX_S] <= reg_wdata[PRIO_W-1:0];
                    default:     ;
                endcase
            end
        end
    end

    // Read mux; bit positions in the mask registers equal source ids
    always_comb begin
        w_rdata = '0;
        if (!w_addr[7]) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_addr[6:2] == c_id_w'(i + 1)) begin
                    w_rdata = 32'(r_prio[i]);
                end
            end
        end else begin
            case (w_addr)
                c_reg_pend:    w_rdata = 32'({w_pend, 1'b0});
                c_reg_en_m:    w_rdata = 32'({r_en[CTX_M], 1'b0});
                c_reg_en_s:    w_rdata = 32'({r_en[CTX_S], 1'b0});
                c_reg_thr_m:   w_rdata = 32'(r_thr[CTX_M]);
                c_reg_thr_s:   w_rdata = 32'(r_thr[CTX_S]);
                c_reg_claim_m: w_rdata = 32'(r_best[CTX_M]);
                c_reg_claim_s: w_rdata = 32'(r_best[CTX_S]);
                default:       ;
            endcase
        end
    end

    // Read data is captured on the accept edge and held through the response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= reg_we ? '0 : w_rdata;
        end
    end

    // Access FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access FSM next state: accept in IDLE, respond for exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (reg_valid) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A reset arriving during the response cycle suppresses the completion pulse
    assign reg_ready = (r_state == RESP) && !reset;
    assign reg_rdata = r_rdata;
    assign eip_m     = r_eip[CTX_M];
    assign eip_s     = r_eip[CTX_S];

endmodule
`default_nettype wire

// File: tb/tb_plic_lite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plic_lite
//  Description : Self-checking bench for plic_lite: register table, directed
//                claim/complete sequences and a randomized run against a
//                behavioural model of the gateways and arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_plic_lite;

    localparam int N  = 8;
    localparam int PW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_src;
    logic         reg_valid;
    logic         reg_we;
    logic [7:0]   reg_addr;
    logic [31:0]  reg_wdata;
    logic [31:0]  reg_rdata;
    logic         reg_ready;
    logic         eip_m;
    logic         eip_s;

    int           errors = 0;
    int           checks = 0;
    logic [1:0]   eip_at_ready;
    logic [31:0]  rdv;

    // Behavioural model state, indexed by source id (1..N)
    int           m_prio [32];
    bit           m_pend [32];
    bit           m_infl [32];
    logic [31:0]  m_en   [2];
    int           m_thr  [2];

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] want;
    } vec_t;

    vec_t tbl [14];

    plic_lite #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .reg_valid (reg_valid),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .eip_m     (eip_m),
        .eip_s     (eip_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_prio[i] = 0;
            m_pend[i] = 0;
            m_infl[i] = 0;
        end
        m_en[0]  = '0;
        m_en[1]  = '0;
        m_thr[0] = 0;
        m_thr[1] = 0;
    endtask

    // Level sources latch into pending unless the id is already in service
    task automatic m_settle();
        for (int id = 1; id <= N; id++) begin
            if (irq_src[id-1] && !m_infl[id]) m_pend[id] = 1;
        end
    endtask

    // Walk priority levels from highest down; first eligible id at a level wins
    function automatic int ref_best(int c);
        for (int p = (1 << PW) - 1; p >= 1; p--) begin
            if (p <= m_thr[c]) break;
            for (int id = 1; id <= N; id++) begin
                if (m_pend[id] && m_en[c][id] && (m_prio[id] == p)) return id;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_pend_word();
        logic [31:0] w;
        w = '0;
        for (int id = 1; id <= N; id++) w[id] = m_pend[id];
        return w;
    endfunction

    task automatic do_reset(input logic [N-1:0] irq);
        @(negedge clk);
        reset     = 1'b1;
        reg_valid = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        irq_src   = irq;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_clear();
    endtask

    task automatic access(input bit we, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int cnt;
        @(negedge clk);
        reg_valid = 1'b1;
        reg_we    = we;
        reg_addr  = a;
        reg_wdata = d;
        cnt = 0;
        rd  = '0;
        forever begin
            @(negedge clk);
            if (reg_ready) break;
            cnt++;
            if (cnt > 10) break;
        end
        if (cnt > 10) begin
            check("access_timeout", 32'(cnt), 32'd0);
        end else begin
            rd           = reg_rdata;
            eip_at_ready = {eip_s, eip_m};
        end
        @(posedge clk);
        #1 reg_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        access(1'b1, a, d, unused_rd);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] want);
        logic [31:0] v;
        access(1'b0, a, 32'd0, v);
        check(nm, v, want);
    endtask

    initial begin
        int ready_seen;

        // ---------------- reset state with all sources high ----------------
        reset     = 1'b1;
        reg_valid = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        irq_src   = '1;
        m_clear();
        repeat (3) @(negedge clk);
        check("rst_eip_m", 32'(eip_m), 32'd0);
        check("rst_eip_s", 32'(eip_s), 32'd0);
        check("rst_ready", 32'(reg_ready), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_eip_m", 32'(eip_m), 32'd0);
        check("post_rst_eip_s", 32'(eip_s), 32'd0);
        rd_chk("rst_pending", 8'h80, 32'h1FE);

        // ---------------- register table ----------------
        tbl[0]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{1'b0, 8'h08, 32'h0,         32'h7};
        tbl[2]  = '{1'b1, 8'h00, 32'h5,         32'h0};
        tbl[3]  = '{1'b0, 8'h00, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 8'h24, 32'h3,         32'h0};
        tbl[5]  = '{1'b0, 8'h24, 32'h0,         32'h0};
        tbl[6]  = '{1'b1, 8'h20, 32'h4,         32'h0};
        tbl[7]  = '{1'b0, 8'h21, 32'h0,         32'h4};
        tbl[8]  = '{1'b1, 8'h84, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{1'b0, 8'h84, 32'h0,         32'h1FE};
        tbl[10] = '{1'b1, 8'h88, 32'h0000_0201, 32'h0};
        tbl[11] = '{1'b0, 8'h88, 32'h0,         32'h0};
        tbl[12] = '{1'b1, 8'h90, 32'h0000_000A, 32'h0};
        tbl[13] = '{1'b0, 8'h93, 32'h0,         32'h2};
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            else           rd_chk($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].want);
        end
        wr(8'hA0, 32'h1234);
        rd_chk("unmapped", 8'hA0, 32'h0);

        // ---------------- priority order and ties ----------------
        do_reset('0);
        wr(8'h0C, 32'd5);
        wr(8'h14, 32'd5);
        wr(8'h08, 32'd7);
        wr(8'h84, 32'h2C);
        wr(8'h8C, 32'd4);
        @(negedge clk);
        irq_src = 8'h16;
        repeat (4) @(negedge clk);
        check("order_eip_m", 32'(eip_m), 32'd1);
        check("order_eip_s", 32'(eip_s), 32'd0);
        rd_chk("claim_1st", 8'h94, 32'd2);
        rd_chk("claim_2nd", 8'h94, 32'd3);
        rd_chk("claim_3rd", 8'h94, 32'd5);
        check("eip_m_at_3rd", 32'(eip_at_ready[0]), 32'd1);
        @(negedge clk);
        check("eip_m_dropped", 32'(eip_m), 32'd0);
        rd_chk("claim_empty", 8'h94, 32'd0);

        // ---------------- threshold masks equal priority ----------------
        wr(8'h94, 32'd2);
        wr(8'h8C, 32'd7);
        repeat (4) @(negedge clk);
        check("thr_eip_m", 32'(eip_m), 32'd0);
        rd_chk("thr_claim", 8'h94, 32'd0);
        rd_chk("thr_pending", 8'h80, 32'h04);

        // ---------------- no re-pend until complete ----------------
        do_reset('0);
        wr(8'h10, 32'd2);
        wr(8'h84, 32'h10);
        @(negedge clk);
        irq_src = 8'h08;
        repeat (4) @(negedge clk);
        rd_chk("claim4", 8'h94, 32'd4);
        repeat (4) @(negedge clk);
        check("inflight_eip_m", 32'(eip_m), 32'd0);
        rd_chk("inflight_pend", 8'h80, 32'h0);
        wr(8'h94, 32'd9);
        repeat (3) @(negedge clk);
        rd_chk("bad_cmpl_pend", 8'h80, 32'h0);
        check("bad_cmpl_eip", 32'(eip_m), 32'd0);
        wr(8'h94, 32'd4);
        @(negedge clk);
        check("cmpl_eip_e1", 32'(eip_m), 32'd0);
        @(negedge clk);
        check("cmpl_eip_e2", 32'(eip_m), 32'd1);
        rd_chk("cmpl_pend", 8'h80, 32'h10);

        // ---------------- shared source across contexts ----------------
        do_reset('0);
        wr(8'h18, 32'd1);
        wr(8'h84, 32'h40);
        wr(8'h88, 32'h40);
        @(negedge clk);
        irq_src = 8'h20;
        repeat (4) @(negedge clk);
        check("shared_eip_m", 32'(eip_m), 32'd1);
        check("shared_eip_s", 32'(eip_s), 32'd1);
        rd_chk("shared_claim_m", 8'h94, 32'd6);
        @(negedge clk);
        check("shared_drop_m", 32'(eip_m), 32'd0);
        check("shared_drop_s", 32'(eip_s), 32'd0);
        rd_chk("shared_claim_s", 8'h98, 32'd0);

        // ---------------- reset during response cycle ----------------
        do_reset('0);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 8'h84;
        reg_wdata = 32'hFF;
        ready_seen = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        if (reg_ready) ready_seen++;
        @(posedge clk);
        #1 reg_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (reg_ready) ready_seen++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reg_ready) ready_seen++;
        end
        check("rst_resp_ready", 32'(ready_seen), 32'd0);
        rd_chk("rst_resp_en_m", 8'h84, 32'h0);

        // ---------------- randomized run against the model ----------------
        do_reset('0);
        for (int it = 0; it < 300; it++) begin
            int          op;
            int          c;
            int          id;
            logic [31:0] d;
            logic [31:0] v;
            op = $urandom_range(0, 7);
            c  = $urandom_range(0, 1);
            d  = $urandom();
            case (op)
                0: begin
                    @(negedge clk);
                    irq_src = N'($urandom());
                end
                1: begin
                    id = (it < 40) ? $urandom_range(1, N) : $urandom_range(0, 31);
                    wr(8'(id * 4 + $urandom_range(0, 3)), d);
                    if (id >= 1 && id <= N) m_prio[id] = int'(d[PW-1:0]);
                end
                2: begin
                    wr(c ? 8'h88 : 8'h84, d);
                    m_en[c] = d & 32'h0000_01FE;
                end
                3: begin
                    d = 32'($urandom_range(0, 15));
                    wr(c ? 8'h90 : 8'h8C, d);
                    m_thr[c] = int'(d[PW-1:0]);
                end
                4, 5: begin
                    id = ref_best(c);
                    access(1'b0, c ? 8'h98 : 8'h94, 32'd0, v);
                    check($sformatf("rnd_claim_%0d", c), v, 32'(id));
                    if (id != 0) begin
                        m_pend[id] = 0;
                        m_infl[id] = 1;
                    end
                end
                6: begin
                    id = $urandom_range(0, 10);
                    wr(c ? 8'h98 : 8'h94, 32'(id));
                    if (id >= 1 && id <= N) m_infl[id] = 0;
                end
                default: begin
                    id = $urandom_range(0, N + 1);
                    rd_chk("rnd_pend", 8'h80, m_pend_word());
                    rd_chk("rnd_prio", 8'(id * 4), (id >= 1 && id <= N) ? 32'(m_prio[id]) : 32'd0);
                end
            endcase
            repeat (3) @(posedge clk);
            m_settle();
            @(negedge clk);
            check("rnd_eip_m", 32'(eip_m), 32'(ref_best(0) != 0));
            check("rnd_eip_s", 32'(eip_s), 32'(ref_best(1) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
